// File: rtl/doa_pkg.sv
// Shared definitions for the weight lookup block.
//   state_e       : lookup FSM states (IDLE, RUN)
//   DEF_*         : default parameter values for N_ADDR / DIN_WIDTH / W_WIDTH
package doa_pkg;

    localparam int unsigned DEF_N_ADDR    = 256;
    localparam int unsigned DEF_DIN_WIDTH = 16;
    localparam int unsigned DEF_W_WIDTH   = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/bram_infer.sv
// Simple dual-port block RAM template, no reset and no initial contents.
// The read is registered (one cycle latency) and returns the old contents
// when the same address is written in the same cycle.
//   clk     : clock for both ports
//   i_wen   : write enable      i_waddr : write address   i_wdata : write data
//   i_ren   : read enable       i_raddr : read address    o_rdata : read data
module bram_infer #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned WIDTH = 16,
    parameter int unsigned AW    = 8
) (
    input  logic             clk,
    input  logic             i_wen,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_ren,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // Non-blocking write and read in one process give read-before-write.
    always_ff @(posedge clk) begin
        if (i_wen) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_ren) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/weight_lookup.sv
// Pairs each input sample with a per-position weight from an on-chip table.
// Weights are loaded through the cfg_* port; samples are framed by sync_in.
//   clk, rst_n              : clock, asynchronous active-low reset
//   din, din_valid, sync_in : sample stream, sync marks the first of a frame
//   cfg_start, cfg_wen,
//   cfg_wdata               : weight loading (restart at 0, write strobe, data)
//   dout, w_out, dout_valid : sample and its weight, two cycles after input
//   sync_out                : first output of a frame
//   frame_err               : sticky, set by a sync arriving before frame end
//   load_done               : N_ADDR weights written since the last cfg_start
module weight_lookup
    import doa_pkg::*;
#(
    parameter int unsigned N_ADDR    = DEF_N_ADDR,
    parameter int unsigned DIN_WIDTH = DEF_DIN_WIDTH,
    parameter int unsigned W_WIDTH   = DEF_W_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DIN_WIDTH-1:0] din,
    input  logic                 din_valid,
    input  logic                 sync_in,
    input  logic                 cfg_start,
    input  logic                 cfg_wen,
    input  logic [W_WIDTH-1:0]   cfg_wdata,
    output logic [DIN_WIDTH-1:0] dout,
    output logic [W_WIDTH-1:0]   w_out,
    output logic                 dout_valid,
    output logic                 sync_out,
    output logic                 frame_err,
    output logic                 load_done
);

    localparam int unsigned     AW   = (N_ADDR > 1) ? $clog2(N_ADDR) : 1;
    localparam logic [AW-1:0]   LAST = AW'(N_ADDR - 1);

    // Lookup path
    state_e               r_state;
    state_e               w_state_nxt;
    logic [AW-1:0]        r_rd_addr;
    logic [AW-1:0]        w_rd_addr;
    logic                 w_start;
    logic                 w_ren;
    logic                 w_early;
    logic                 r_frame_err;
    logic                 r_vld_d1;
    logic                 r_sync_d1;
    logic [DIN_WIDTH-1:0] r_din_d1;
    logic [W_WIDTH-1:0]   w_rdata;
    logic [DIN_WIDTH-1:0] r_dout;
    logic [W_WIDTH-1:0]   r_w_out;
    logic                 r_dout_valid;
    logic                 r_sync_out;

    // Load path
    logic [AW-1:0]        r_wr_addr;
    logic [AW-1:0]        w_wr_addr;
    logic                 w_wen;
    logic                 r_load_done;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and read-side decode
    always_comb begin
        w_state_nxt = r_state;
        w_start     = sync_in & din_valid;
        // In IDLE only a sync-qualified sample starts a read.
        w_ren       = din_valid & ((r_state == RUN) | sync_in);
        w_early     = w_start & (r_state == RUN) & (r_rd_addr != LAST);

        if (w_start) begin
            w_state_nxt = RUN;
        end

        // Address presented to the RAM this cycle; r_rd_addr holds the last one read.
        if (w_start || (r_rd_addr == LAST)) begin
            w_rd_addr = '0;
        end else begin
            w_rd_addr = r_rd_addr + 1'b1;
        end
    end

    // Read counter, error flag and the two-stage output pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_addr    <= '0;
            r_frame_err  <= 1'b0;
            r_vld_d1     <= 1'b0;
            r_sync_d1    <= 1'b0;
            r_din_d1     <= '0;
            r_dout       <= '0;
            r_w_out      <= '0;
            r_dout_valid <= 1'b0;
            r_sync_out   <= 1'b0;
        end else begin
            if (w_ren) begin
                r_rd_addr <= w_rd_addr;
                r_din_d1  <= din;
            end
            if (w_early) begin
                r_frame_err <= 1'b1;
            end
            r_vld_d1     <= w_ren;
            r_sync_d1    <= w_start;
            r_dout_valid <= r_vld_d1;
            r_sync_out   <= r_vld_d1 & r_sync_d1;
            // Outputs hold their last pair while nothing valid is in flight.
            if (r_vld_d1) begin
                r_dout  <= r_din_d1;
                r_w_out <= w_rdata;
            end
        end
    end

    // Load path decode: cfg_start in the same cycle as a write targets address 0.
    always_comb begin
        w_wr_addr = cfg_start ? '0 : r_wr_addr;
        w_wen     = cfg_wen & (cfg_start | ~r_load_done);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_addr   <= '0;
            r_load_done <= 1'b0;
        end else if (w_wen) begin
            r_load_done <= (w_wr_addr == LAST);
            r_wr_addr   <= (w_wr_addr == LAST) ? '0 : w_wr_addr + 1'b1;
        end else if (cfg_start) begin
            r_wr_addr   <= '0;
            r_load_done <= 1'b0;
        end
    end

    bram_infer #(
        .DEPTH (N_ADDR),
        .WIDTH (W_WIDTH),
        .AW    (AW)
    ) u_bram (
        .clk     (clk),
        .i_wen   (w_wen),
        .i_waddr (w_wr_addr),
        .i_wdata (cfg_wdata),
        .i_ren   (w_ren),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rdata)
    );

    assign dout       = r_dout;
    assign w_out      = r_w_out;
    assign dout_valid = r_dout_valid;
    assign sync_out   = r_sync_out;
    assign frame_err  = r_frame_err;
    assign load_done  = r_load_done;

endmodule

// File: doc/weight_lookup.md
WEIGHT_LOOKUP -- requirements
Module: weight_lookup

Interface
REQ-001 Parameter N_ADDR, default 256: weights per frame; also BRAM depth.
REQ-002 Parameter DIN_WIDTH, default 16: sample width.
REQ-003 Parameter W_WIDTH, default 16: weight width.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 clk  in  1  rising-edge clock for all logic.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 din  in  DIN_WIDTH  input sample.
REQ-008 din_valid  in  1  din qualifier.
REQ-009 sync_in  in  1  frame start, valid only together with din_valid.
REQ-010 cfg_start  in  1  pulse that restarts weight loading at address 0.
REQ-011 cfg_wen  in  1  weight write strobe.
REQ-012 cfg_wdata  in  W_WIDTH  weight to write.
REQ-013 dout  out  DIN_WIDTH  sample aligned with its weight.
REQ-014 w_out  out  W_WIDTH  weight for dout.
REQ-015 dout_valid  out  1  dout/w_out qualifier.
REQ-016 sync_out  out  1  marks the first output of a frame.
REQ-017 frame_err  out  1  sticky flag for an early sync.
REQ-018 load_done  out  1  high once N_ADDR weights have been written since the last cfg_start.

Function
REQ-019 FSM states: IDLE and RUN. Reset enters IDLE. IDLE to RUN on sync_in&din_valid. RUN has no exit except reset.
REQ-020 In IDLE, din_valid without sync_in SHALL be ignored: no BRAM read and no output.
REQ-021 Read address: 0 on sync_in&din_valid; +1 on each other din_valid in RUN; wraps N_ADDR-1 to 0 (free-runs if sync is missing).
REQ-022 BRAM ren SHALL equal din_valid qualified by (RUN or sync_in).
REQ-023 Latency: a qualified din_valid at cycle t SHALL give dout_valid at t+2, with dout=din(t) and w_out=mem[addr(t)]. This is 1 BRAM cycle plus 1 output register. Full throughput, no bubbles.
REQ-024 sync_out SHALL be sync_in delayed by 2 cycles, gated by the same qualification.
REQ-025 A sync_in in RUN with the address counter not at N_ADDR-1 (early sync) SHALL set frame_err and restart at 0. frame_err clears only on reset.
REQ-026 When dout_valid=0, dout and w_out SHALL hold their last values.
REQ-027 Load path: cfg_start sets write address to 0 and clears load_done.
REQ-028 Each cfg_wen SHALL write cfg_wdata to the write address, then increment it.
REQ-029 After the N_ADDR-th write, load_done=1 and further cfg_wen SHALL be ignored until the next cfg_start.
REQ-030 cfg_start and cfg_wen in the same cycle SHALL write address 0, and the next address SHALL be 1.
REQ-031 A read and a write to the same address in the same cycle SHALL return the old contents (read-before-write). Loading while in RUN is legal.

Reset
REQ-032 On rst_n=0, all outputs SHALL be 0, state SHALL be IDLE, and both counters SHALL be 0, immediately and without a clock.
REQ-033 Reset mid-frame SHALL drop in-flight samples. BRAM contents SHALL be preserved, but load_done=0 until reloaded.

Structure
REQ-034 Shared package doa_pkg SHALL hold the state enumeration (IDLE, RUN) and default width constants.
REQ-035 One sub-module: bram_infer, built without _init_mem_. Its write port is the load path and its read port is the lookup path.
REQ-036 bram_infer has no reset, so all reset values SHALL come from this block's registers.

Verification
REQ-037 With N_ADDR=8: load weights 10..17, then drive a sync frame with din=100..107. Required: load_done=1; dout_valid pairs (100,10)..(107,17), each 2 cycles after input; sync_out on the first pair.
REQ-038 With N_ADDR=8: drive din_valid for 5 cycles with no sync in IDLE. Required: no dout_valid, no ren.
REQ-039 With N_ADDR=8: drive 12 valids after sync. Required: samples 9..12 pair with weights 10..13 (wrap); frame_err=0.
REQ-040 With N_ADDR=8: assert sync on the 4th sample of a frame. Required: frame_err=1 and stays 1; that sample pairs with weight 10.
REQ-041 With N_ADDR=8: send 10 cfg_wen after cfg_start. Required: only the first 8 are written; load_done=1. A simultaneous cfg_start+cfg_wen=55 then gives mem[0]=55 and load_done=0.
REQ-042 Assert rst_n low mid-stream, asynchronously. Required: outputs 0 that cycle; the frame after reset pairs against the preserved weights.
